// File: rtl/md_unit.sv
// ============================================================================
// md_unit
// ----------------------------------------------------------------------------
// Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline.
// Holds the architectural HI/LO registers, executes mult/multu/div/divu
// with a fixed multi-cycle latency and services mthi/mtlo in one cycle.
// The result of a multi-cycle operation is computed when the operation is
// accepted, parked in a pending register, and committed to HI/LO on the
// same edge that busy falls.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-low reset
//   start  in   1   E-stage instruction is an md instruction
//   md_op  in   3   000 mult, 001 multu, 010 div, 011 divu,
//                   100 mthi, 101 mtlo, 110/111 no-op
//   A      in  32   forwarded rs value
//   B      in  32   forwarded rt value
//   hi     out 32   architectural HI register
//   lo     out 32   architectural LO register
//   busy   out  1   multi-cycle operation in progress
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_valid;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic               div_zero;
    logic               div_ovf;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_valid;
    logic        is_md_long;
    logic        is_div;

    // Datapath: every candidate result is formed from the operands at the
    // accepting edge. The divisor is forced to 1 on divide-by-zero so the
    // dividers never see a zero operand; that result is discarded anyway.
    // The signed-overflow case is special-cased rather than trusting the
    // wrap behaviour of the signed divide operator.
    always_comb begin
        prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u   = {32'b0, A} * {32'b0, B};
        div_zero = (B == 32'b0);
        div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        divisor  = div_zero ? 32'd1 : B;
        quot_u   = A / divisor;
        rem_u    = A % divisor;
        if (div_ovf) begin
            quot_s = 32'sh8000_0000;
            rem_s  = 32'sh0;
        end else begin
            quot_s = $signed(A) / $signed(divisor);
            rem_s  = $signed(A) % $signed(divisor);
        end

        res_hi    = 32'b0;
        res_lo    = 32'b0;
        res_valid = 1'b1;
        case (md_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi    = rem_s;
                res_lo    = quot_s;
                res_valid = !div_zero;
            end
            OP_DIVU: begin
                res_hi    = rem_u;
                res_lo    = quot_u;
                res_valid = !div_zero;
            end
            default: res_valid = 1'b0;
        endcase

        is_md_long = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                     (md_op == OP_DIV)  || (md_op == OP_DIVU);
        is_div     = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    end

    // Control FSM and architectural registers. In RUN, start is ignored, and
    // the commit happens on the edge where cnt steps from 1 to 0 so that busy
    // and the new HI/LO appear together. A divide-by-zero still runs the full
    // sequence but leaves p_valid low, so nothing is committed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            p_hi    <= 32'b0;
            p_lo    <= 32'b0;
            p_valid <= 1'b0;
            hi      <= 32'b0;
            lo      <= 32'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_md_long) begin
                            p_hi    <= res_hi;
                            p_lo    <= res_lo;
                            p_valid <= res_valid;
                            cnt     <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            state   <= RUN;
                            busy    <= 1'b1;
                        end else if (md_op == OP_MTHI) begin
                            hi <= A;
                        end else if (md_op == OP_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt <= 4'd1) begin
                        cnt     <= 4'd0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        p_valid <= 1'b0;
                        if (p_valid) begin
                            hi <= p_hi;
                            lo <= p_lo;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ============================================================================
// tb_md_unit
// ----------------------------------------------------------------------------
// Directed bench for md_unit: multiply/divide results, latencies, mthi/mtlo,
// divide-by-zero, signed overflow, start-during-RUN and asynchronous reset.
// Expected values are hand-computed constants.
// ============================================================================
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a_val;
    logic [31:0] b_val;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int checks;
    int errors;
    int n_busy;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (a_val),
        .B     (b_val),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value with its expected value
    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Checks hi, lo and busy together
    task automatic checkOutput(input string tag, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input logic exp_busy);
        checkValue({tag, ".hi"}, hi, exp_hi);
        checkValue({tag, ".lo"}, lo, exp_lo);
        checkValue({tag, ".busy"}, {31'b0, busy}, {31'b0, exp_busy});
    endtask

    // Presents one instruction for a single edge; returns 1 ns after it
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        a_val = av;
        b_val = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'b110;
    endtask

    // Counts samples with busy high, bounded so a stuck busy cannot hang
    task automatic waitIdle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        md_op  = 3'b110;
        a_val  = 32'b0;
        b_val  = 32'b0;

        #12;
        checkOutput("reset", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // mult -1 * 2, hi/lo must hold old values while busy
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0002);
        for (int i = 0; i < 4; i++) begin
            checkOutput("mult_run", 32'h0, 32'h0, 1'b1);
            @(posedge clk);
            #1;
        end
        checkOutput("mult_last", 32'h0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("mult_done", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);

        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'h0000_0002);
        waitIdle(n_busy);
        checkValue("multu_lat", n_busy, 32'd5);
        checkOutput("multu", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
        waitIdle(n_busy);
        checkValue("div_lat", n_busy, 32'd10);
        checkOutput("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        applyStimulus(3'b011, 32'd7, 32'd2);
        waitIdle(n_busy);
        checkValue("divu_lat", n_busy, 32'd10);
        checkOutput("divu", 32'd1, 32'd3, 1'b0);

        applyStimulus(3'b100, 32'h1234_5678, 32'h0);
        checkOutput("mthi", 32'h1234_5678, 32'd3, 1'b0);

        applyStimulus(3'b011, 32'd99, 32'd0);
        waitIdle(n_busy);
        checkValue("divz_lat", n_busy, 32'd10);
        checkOutput("divz", 32'h1234_5678, 32'd3, 1'b0);

        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(n_busy);
        checkOutput("div_ovf", 32'h0, 32'h8000_0000, 1'b0);

        applyStimulus(3'b101, 32'hCAFE_BABE, 32'h0);
        checkOutput("mtlo", 32'h0, 32'hCAFE_BABE, 1'b0);

        applyStimulus(3'b110, 32'hDEAD_BEEF, 32'h1);
        checkOutput("nop110", 32'h0, 32'hCAFE_BABE, 1'b0);
        applyStimulus(3'b111, 32'hDEAD_BEEF, 32'h1);
        checkOutput("nop111", 32'h0, 32'hCAFE_BABE, 1'b0);

        // div 100/7 with a stray mult issued in cycle 3 of the RUN
        applyStimulus(3'b010, 32'd100, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        md_op = 3'b000;
        a_val = 32'd5;
        b_val = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 3'b110;
        checkOutput("div_ign_run", 32'h0, 32'hCAFE_BABE, 1'b1);
        waitIdle(n_busy);
        checkValue("div_ign_lat", n_busy, 32'd7);
        checkOutput("div_ign", 32'd2, 32'd14, 1'b0);

        // asynchronous reset in cycle 4 of a mult
        applyStimulus(3'b000, 32'd3, 32'd4);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_mid", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("rst_nocommit", 32'h0, 32'h0, 1'b0);

        applyStimulus(3'b000, 32'd6, 32'd7);
        waitIdle(n_busy);
        checkValue("mult2_lat", n_busy, 32'd5);
        checkOutput("mult2", 32'h0, 32'd42, 1'b0);

        applyStimulus(3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        waitIdle(n_busy);
        checkOutput("mult_negneg", 32'h0, 32'd15, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu over a fixed multi-cycle latency.
- Services mthi/mtlo in a single cycle and holds the architectural HI/LO registers.
- Drives `busy`, which the D-stage hazard/stall unit combines with the E-stage md-instruction check to stall md instructions in decode.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is an md instruction; sampled on rising clk.
- md_op  input  3  opcode: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 no-op.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.
- busy  output  1  multi-cycle operation in progress.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While reset=0: hi=0, lo=0, busy=0, counter=0, pending result cleared.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded and never committed.
- States:
  - IDLE (busy=0).
  - RUN (busy=1): 4-bit down-counter `cnt` plus 64-bit pending register {p_hi, p_lo}.
- IDLE, start=1, md_op in {mult, multu, div, divu}, at edge N:
  - Compute the result from A/B as sampled at edge N; store it in {p_hi, p_lo}.
  - Load cnt = MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy is high from cycle N+1 through N+K (K = loaded latency).
- RUN, each edge: cnt decrements. On the edge where cnt reaches 0:
  - Commit hi<=p_hi, lo<=p_lo and return to IDLE.
  - busy and new hi/lo change on the same edge; no cycle shows busy=0 with stale hi/lo.
- mthi/mtlo with start=1 in IDLE: hi<=A (mthi) or lo<=A (mtlo) at edge N; busy stays 0.
- start=1 during RUN: ignored. The stall unit guarantees this cannot occur; the block must not corrupt state if it does.
- Arithmetic:
  - mult: {hi, lo} = signed(A) * signed(B), 64-bit two's complement.
  - multu: {hi, lo} = unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder, sign of dividend (A).
  - divu: unsigned quotient in lo, unsigned remainder in hi.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - Divide by zero (B=0, div or divu): full busy sequence of DIV_CYCLES, but hi/lo keep their prior values; no commit.
- mfhi/mflo read hi/lo combinationally outside this block. During RUN, hi/lo show pre-operation values.
- md_op 110/111 with start=1: no state change.
- start and md_op must be valid at every edge; X on start is not tolerated.

Test Plan:
- mult, A=0xFFFFFFFF, B=0x00000002, start at edge 0 -> busy=1 cycles 1–5, falls at edge 5; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged during cycles 1–4.
- multu, same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, A=7, B=2 -> lo=3, hi=1.
- divu with B=0 after mthi A=0x12345678 -> busy 10 cycles, hi stays 0x12345678, lo unchanged. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mtlo A=0xCAFEBABE -> lo updates at the next edge, busy never asserts. start=1 mult issued in cycle 3 of a div RUN -> ignored; div result commits unchanged.
- reset driven low asynchronously at cycle 4 of a mult -> busy=0, hi=lo=0 immediately; no commit after reset releases; next mult completes normally in 5 cycles.
